// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI types, wire-format constants and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEAD     = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_TRAIL    = 3'd4,
    ST_GAP      = 3'd5
  } spi_state_e;

  // Wire format shared with spi_slave: mode 0, LSB first.
  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_if
// Description : Request/response and serial pins of the SPI initiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] send;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] recv;
  logic             output_valid;
  logic             sclk;
  logic             csn;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, send, miso,
    output ready, busy, recv, output_valid, sclk, csn, mosi
  );

  modport slave (
    output start, send, miso,
    input  ready, busy, recv, output_valid, sclk, csn, mosi
  );
endinterface
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : Half-period counter 0..CLK_DIV-1 with terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int               CNT_W  = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tc    = en && (cnt_q == TC_VAL);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Mode-0, LSB-first SPI initiator, full duplex, WIDTH-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_if.master    bus
);

  localparam int               BIT_W    = clog2(WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(WIDTH);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] recv_q, recv_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             csn_q, csn_d;
  logic             mosi_q, mosi_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;

  logic             div_idle;
  logic             tc;
  logic             accept;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;

  assign div_idle = (state_q == ST_IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk (clk),
    .rst (rst),
    .en  (!div_idle),
    .clr (div_idle),
    .tc  (tc)
  );

  // A start landing on the final GAP cycle is taken directly, so back-to-back
  // words see exactly one half-period of csn high.
  assign accept   = bus.start && (div_idle || (state_q == ST_GAP && tc));
  assign tx_shift = tx_q >> 1;
  assign rx_shift = WIDTH'({bus.miso, rx_q} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      recv_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= CPOL;
      csn_q   <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      recv_q  <= recv_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus.start) state_d = ST_LEAD;
      ST_LEAD:     if (tc) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tc) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tc) state_d = (bit_q == ALL_BITS) ? ST_TRAIL : ST_SHIFT_HI;
      ST_TRAIL:    if (tc) state_d = ST_GAP;
      ST_GAP:      if (tc) state_d = bus.start ? ST_LEAD : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // After the last high phase the bit counter reaches WIDTH; the following low
  // phase then completes the final sclk period without another rising edge.
  always_comb begin
    tx_d    = tx_q;
    rx_d    = rx_q;
    recv_d  = recv_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    csn_d   = csn_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    if (accept) begin
      tx_d    = bus.send;
      mosi_d  = bus.send[0];
      csn_d   = 1'b0;
      bit_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_LEAD: begin
          if (tc) begin
            sclk_d = ~CPOL;
            rx_d   = rx_shift;
          end
        end
        ST_SHIFT_HI: begin
          if (tc) begin
            sclk_d = CPOL;
            bit_d  = bit_q + 1'b1;
            if (bit_q != LAST_BIT) begin
              tx_d   = tx_shift;
              mosi_d = tx_shift[0];
            end
          end
        end
        ST_SHIFT_LO: begin
          if (tc && (bit_q != ALL_BITS)) begin
            sclk_d = ~CPOL;
            rx_d   = rx_shift;
          end
        end
        ST_TRAIL: begin
          if (tc) begin
            csn_d   = 1'b1;
            mosi_d  = 1'b0;
            recv_d  = rx_q;
            valid_d = 1'b1;
          end
        end
        ST_GAP: begin
          if (tc) ready_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sclk         = sclk_q;
  assign bus.csn          = csn_q;
  assign bus.mosi         = mosi_q;
  assign bus.ready        = ready_q;
  assign bus.busy         = ~ready_q;
  assign bus.recv         = recv_q;
  assign bus.output_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Directed, table-driven bench for spi_master with a slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.WIDTH(8))  bus8();
  spi_master_if #(.WIDTH(16)) bus16();

  spi_master #(.WIDTH(8),  .CLK_DIV(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  spi_master #(.WIDTH(16), .CLK_DIV(1)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Mode-0 LSB-first slave model, clocked from clk and watching the pins.
  logic       use_slave  = 1'b0;
  logic [7:0] slave_send = 8'h00;
  logic       s_csn_p    = 1'b1;
  logic       s_sclk_p   = 1'b0;
  logic [7:0] s_tx       = 8'h00;
  logic [7:0] s_rx       = 8'h00;
  logic [7:0] s_recv     = 8'h00;
  logic       s_miso     = 1'b0;
  int         s_valid_cnt = 0;

  always @(posedge clk) begin
    s_csn_p  <= bus8.csn;
    s_sclk_p <= bus8.sclk;
    if (s_csn_p && !bus8.csn) begin
      s_tx   <= slave_send;
      s_miso <= slave_send[0];
    end else if (!bus8.csn) begin
      if (!s_sclk_p && bus8.sclk) s_rx <= {bus8.mosi, s_rx[7:1]};
      if (s_sclk_p && !bus8.sclk) begin
        s_tx   <= s_tx >> 1;
        s_miso <= s_tx[1];
      end
    end
    if (!s_csn_p && bus8.csn) begin
      s_recv      <= s_rx;
      s_valid_cnt <= s_valid_cnt + 1;
    end
  end

  assign bus8.miso  = use_slave ? s_miso : bus8.mosi;
  assign bus16.miso = bus16.mosi;

  // Pin monitor for the 8-bit instance.
  logic prev_sclk8 = 1'b0;
  logic mosi_log [0:255];
  int   rise_cnt  = 0;
  int   valid_cnt = 0;

  always @(posedge clk) begin
    prev_sclk8 <= bus8.sclk;
    if (bus8.sclk && !prev_sclk8) begin
      mosi_log[rise_cnt % 256] <= bus8.mosi;
      rise_cnt <= rise_cnt + 1;
    end
    if (bus8.output_valid) valid_cnt <= valid_cnt + 1;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n;
    n = 0;
    while (!bus8.ready && n < 300) begin
      tick();
      n++;
    end
    if (!bus8.ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid8(output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (bus8.output_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_xfer(input logic [7:0] d, output int lat);
    wait_ready8();
    bus8.send  = d;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    wait_valid8(lat);
  endtask

  typedef struct {
    logic       use_slave;
    logic [7:0] send;
    logic [7:0] slave_send;
    logic [7:0] exp_recv;
    logic [7:0] exp_slave_recv;
  } vec_t;

  vec_t vecs [6];

  logic [7:0] exp_bits;
  int lat, base, sv, vb, n;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[3] = '{1'b0, 8'hC3, 8'h00, 8'hC3, 8'hC3};
    vecs[4] = '{1'b0, 8'h01, 8'h00, 8'h01, 8'h01};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 8'hFF};

    bus8.start  = 1'b0;
    bus8.send   = 8'h00;
    bus16.start = 1'b0;
    bus16.send  = 16'h0000;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_sclk",  {31'd0, bus8.sclk},  32'd0);
    check("rst_csn",   {31'd0, bus8.csn},   32'd1);
    check("rst_mosi",  {31'd0, bus8.mosi},  32'd0);
    check("rst_ready", {31'd0, bus8.ready}, 32'd1);
    check("rst_busy",  {31'd0, bus8.busy},  32'd0);
    check("rst_valid", {31'd0, bus8.output_valid}, 32'd0);
    check("rst_recv",  {24'd0, bus8.recv},  32'd0);

    // Loopback 136 with exact timing
    base = rise_cnt;
    vb   = valid_cnt;
    bus8.send  = 8'd136;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    check("acc_csn",   {31'd0, bus8.csn},   32'd0);
    check("acc_busy",  {31'd0, bus8.busy},  32'd1);
    check("acc_mosi",  {31'd0, bus8.mosi},  32'd0);
    repeat (71) tick();
    check("lb_valid_71", {31'd0, bus8.output_valid}, 32'd0);
    tick();
    check("lb_valid_72", {31'd0, bus8.output_valid}, 32'd1);
    check("lb_recv",     {24'd0, bus8.recv}, 32'd136);
    check("lb_csn_72",   {31'd0, bus8.csn},  32'd1);
    tick();
    check("lb_valid_73", {31'd0, bus8.output_valid}, 32'd0);
    repeat (2) tick();
    check("lb_ready_75", {31'd0, bus8.ready}, 32'd0);
    tick();
    check("lb_ready_76", {31'd0, bus8.ready}, 32'd1);
    check("lb_rises", rise_cnt - base, 32'd8);
    check("lb_valids", valid_cnt - vb, 32'd1);
    exp_bits = 8'b1000_1000;
    for (int i = 0; i < 8; i++)
      check($sformatf("lb_mosi_bit%0d", i), {31'd0, mosi_log[(base + i) % 256]}, {31'd0, exp_bits[i]});

    // Table-driven transfers, slave model and loopback
    for (int i = 0; i < 6; i++) begin
      wait_ready8();
      use_slave  = vecs[i].use_slave;
      slave_send = vecs[i].slave_send;
      sv = s_valid_cnt;
      do_xfer(vecs[i].send, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd72);
      check($sformatf("v%0d_recv", i), {24'd0, bus8.recv}, {24'd0, vecs[i].exp_recv});
      wait_ready8();
      check($sformatf("v%0d_slave_recv", i), {24'd0, s_recv}, {24'd0, vecs[i].exp_slave_recv});
      check($sformatf("v%0d_slave_valid", i), s_valid_cnt - sv, 32'd1);
    end
    use_slave = 1'b0;

    // Back-to-back with start held high; send changes right after accept
    wait_ready8();
    bus8.send  = 8'h01;
    bus8.start = 1'b1;
    tick();
    bus8.send  = 8'hFF;
    wait_valid8(lat);
    check("b2b_lat1",  lat, 32'd72);
    check("b2b_recv1", {24'd0, bus8.recv}, 32'h01);
    n = 0;
    while (bus8.csn && n < 50) begin
      n++;
      tick();
    end
    check("b2b_csn_high", n, 32'd4);
    check("b2b_ready_low", {31'd0, bus8.ready}, 32'd0);
    bus8.start = 1'b0;
    wait_valid8(lat);
    check("b2b_lat2",  lat, 32'd72);
    check("b2b_recv2", {24'd0, bus8.recv}, 32'hFF);

    // start while busy is ignored
    wait_ready8();
    vb = valid_cnt;
    bus8.send  = 8'hC6;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (k == 30) begin
        bus8.send  = 8'h00;
        bus8.start = 1'b1;
      end
      tick();
      bus8.start = 1'b0;
      if (bus8.output_valid) begin
        lat = k;
        break;
      end
    end
    check("ign_lat",  lat, 32'd72);
    check("ign_recv", {24'd0, bus8.recv}, 32'hC6);
    repeat (100) tick();
    check("ign_valids", valid_cnt - vb, 32'd1);
    check("ign_idle_csn", {31'd0, bus8.csn}, 32'd1);

    // Reset at bit 5, with start asserted alongside rst
    wait_ready8();
    vb = valid_cnt;
    bus8.send  = 8'h33;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (45) tick();
    check("abort_busy_before", {31'd0, bus8.busy}, 32'd1);
    rst = 1'b1;
    bus8.start = 1'b1;
    tick();
    rst = 1'b0;
    bus8.start = 1'b0;
    check("abort_csn",   {31'd0, bus8.csn},   32'd1);
    check("abort_sclk",  {31'd0, bus8.sclk},  32'd0);
    check("abort_ready", {31'd0, bus8.ready}, 32'd1);
    check("abort_recv",  {24'd0, bus8.recv},  32'd0);
    tick();
    check("abort_no_accept", {31'd0, bus8.csn}, 32'd1);
    repeat (100) tick();
    check("abort_no_valid", valid_cnt - vb, 32'd0);
    do_xfer(8'h5A, lat);
    check("post_abort_recv", {24'd0, bus8.recv}, 32'h5A);

    // CLK_DIV=1, WIDTH=16 loopback
    bus16.send  = 16'hBEEF;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tick();
    check("d1_sclk_1", {31'd0, bus16.sclk}, 32'd1);
    tick();
    check("d1_sclk_2", {31'd0, bus16.sclk}, 32'd0);
    tick();
    check("d1_sclk_3", {31'd0, bus16.sclk}, 32'd1);
    tick();
    check("d1_sclk_4", {31'd0, bus16.sclk}, 32'd0);
    lat = -1;
    for (int k = 5; k <= 100; k++) begin
      tick();
      if (bus16.output_valid) begin
        lat = k;
        break;
      end
    end
    check("d1_lat",  lat, 32'd34);
    check("d1_recv", {16'd0, bus16.recv}, 32'hBEEF);
    tick();
    check("d1_ready", {31'd0, bus16.ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
